// File: rtl/bch_enc_framer_pkg.sv
// Shared definitions for the BCH encoder output framer.
//   state_e          : framing FSM states (IDLE / DATA / ECC)
//   *_OFS            : FIFO entry flag offsets, counted upward from BITS
//                      (entry layout is {sop, eop, ecc, data[BITS-1:0]})
//   calc_data_beats  : payload beats per codeword
package bch_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ECC
  } state_e;

  localparam int unsigned ENTRY_FLAG_BITS = 3;
  localparam int unsigned ECC_OFS         = 0;
  localparam int unsigned EOP_OFS         = 1;
  localparam int unsigned SOP_OFS         = 2;

  function automatic int unsigned calc_data_beats(input int unsigned data_bits,
                                                  input int unsigned bits);
    return data_bits / bits;
  endfunction

endpackage

// File: rtl/bch_enc_framer_if.sv
// Framed codeword beat stream toward the NAND page writer.
//   m_data  : output beat
//   m_valid : beat available
//   m_ready : sink accepts beat
//   m_sop   : first beat of codeword
//   m_eop   : last beat of codeword
//   m_ecc   : beat is ECC
// master = framer side, slave = sink side.
interface bch_enc_framer_if #(
  parameter int unsigned BITS = 8
) ();

  logic [BITS-1:0] m_data;
  logic            m_valid;
  logic            m_ready;
  logic            m_sop;
  logic            m_eop;
  logic            m_ecc;

  modport master (
    output m_data, m_valid, m_sop, m_eop, m_ecc,
    input  m_ready
  );

  modport slave (
    input  m_data, m_valid, m_sop, m_eop, m_ecc,
    output m_ready
  );

endinterface

// File: rtl/bch_enc_framer_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   push/wdata : write request (ignored when full)
//   pop/rdata  : read request (ignored when empty); rdata shows the head
//                entry and reads as zero while empty
//   count      : occupancy, 0..DEPTH
//   full/empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module bch_byte_fifo #(
  parameter  int unsigned WIDTH = 11,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bch_enc_framer.sv
// Captures the BCH encoder byte stream, checks codeword framing and
// re-emits framed beats through a FIFO on a valid/ready interface.
//   clk, rst_n      : clock, asynchronous active-low reset
//   enc_data        : encoder data_out
//   enc_first/last  : encoder codeword delimiters
//   enc_data_bits   : beat is payload
//   enc_ecc_bits    : beat is ECC
//   enc_ce          : encoder clock enable, low while the FIFO is full
//   m               : framed output beats (master modport)
//   frame_err       : one-cycle pulse after a framing violation
//   cw_count        : codewords completed without error (wraps)
module bch_enc_framer
  import bch_framer_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 192,
  parameter int unsigned ECC_BYTES  = 8,
  parameter int unsigned BITS       = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BITS-1:0]         enc_data,
  input  logic                    enc_first,
  input  logic                    enc_last,
  input  logic                    enc_data_bits,
  input  logic                    enc_ecc_bits,
  output logic                    enc_ce,
  bch_enc_framer_if.master        m,
  output logic                    frame_err,
  output logic [15:0]             cw_count
);

  localparam int unsigned DATA_BEATS  = calc_data_beats(DATA_BITS, BITS);
  localparam int unsigned FRAME_BEATS = DATA_BEATS + ECC_BYTES;
  localparam int unsigned IDX_W       = $clog2(FRAME_BEATS + 1);
  localparam int unsigned ENT_W       = BITS + ENTRY_FLAG_BITS;
  localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam state_e      AFTER_FIRST = (DATA_BEATS == 1) ? ST_ECC : ST_DATA;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             frame_err_q, frame_err_d;
  logic [15:0]      cw_count_q, cw_count_d;

  logic             accept;
  logic             is_data;
  logic             is_ecc;
  logic             start_frame;
  logic             push_req;
  logic             push_sop;
  logic             push_eop;

  logic             fifo_push;
  logic [ENT_W-1:0] fifo_wdata;
  logic [ENT_W-1:0] fifo_rdata;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  assign enc_ce  = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign accept  = enc_ce & (enc_data_bits | enc_ecc_bits);
  // A beat flagged as both payload and ECC is treated as payload.
  assign is_data = enc_data_bits;
  assign is_ecc  = enc_ecc_bits & ~enc_data_bits;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_err_d = 1'b0;
    cw_count_d  = cw_count_q;
    start_frame = 1'b0;
    push_req    = 1'b0;
    push_sop    = 1'b0;
    push_eop    = 1'b0;

    if (accept) begin
      if (state_q == ST_IDLE) begin
        if (is_data && enc_first && !enc_last) begin
          start_frame = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end else if (enc_first) begin
        // A new first aborts the open frame; a payload beat restarts framing.
        frame_err_d = 1'b1;
        if (is_data) begin
          start_frame = 1'b1;
        end else begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end else if (state_q == ST_DATA) begin
        if (!is_data || enc_last) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
          idx_d       = '0;
        end else begin
          push_req = 1'b1;
          idx_d    = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(DATA_BEATS - 1)) begin
            state_d = ST_ECC;
          end
        end
      end else begin
        if (is_data || (enc_last != (idx_q == IDX_W'(FRAME_BEATS - 1)))) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
          idx_d       = '0;
        end else if (enc_last) begin
          push_req   = 1'b1;
          push_eop   = 1'b1;
          cw_count_d = cw_count_q + 16'd1;
          state_d    = ST_IDLE;
          idx_d      = '0;
        end else begin
          push_req = 1'b1;
          idx_d    = idx_q + IDX_W'(1);
        end
      end
    end

    if (start_frame) begin
      push_req = 1'b1;
      push_sop = 1'b1;
      idx_d    = IDX_W'(1);
      state_d  = AFTER_FIRST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      frame_err_q <= 1'b0;
      cw_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_err_q <= frame_err_d;
      cw_count_q  <= cw_count_d;
    end
  end

  always_comb begin
    fifo_wdata                  = '0;
    fifo_wdata[BITS-1:0]        = enc_data;
    fifo_wdata[BITS + ECC_OFS]  = is_ecc;
    fifo_wdata[BITS + EOP_OFS]  = push_eop;
    fifo_wdata[BITS + SOP_OFS]  = push_sop;
  end

  assign fifo_push = push_req & ~fifo_full;

  bch_byte_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (m.m_ready),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m.m_valid = ~fifo_empty;
  assign m.m_data  = fifo_rdata[BITS-1:0];
  assign m.m_ecc   = fifo_rdata[BITS + ECC_OFS];
  assign m.m_eop   = fifo_rdata[BITS + EOP_OFS];
  assign m.m_sop   = fifo_rdata[BITS + SOP_OFS];

  assign frame_err = frame_err_q;
  assign cw_count  = cw_count_q;

endmodule
